// File: rtl/tms9918_vga_encoder_if.sv
// Video stream bundle between the scan doubler side and the VGA encoder.
// The master drives the doubled-rate pixel stream and VDP vertical sync;
// the slave (the encoder) returns VGA-style sync, data enable and RGB.
interface tms9918_vga_encoder_if;
    logic       clk_en;
    logic       sync_h_in;
    logic       cburst_in;
    logic [3:0] color_in;
    logic       sync_v_in;
    logic       hsync_n;
    logic       vsync_n;
    logic       de;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;

    modport master (
        output clk_en,
        output sync_h_in,
        output cburst_in,
        output color_in,
        output sync_v_in,
        input  hsync_n,
        input  vsync_n,
        input  de,
        input  red,
        input  green,
        input  blue
    );

    modport slave (
        input  clk_en,
        input  sync_h_in,
        input  cburst_in,
        input  color_in,
        input  sync_v_in,
        output hsync_n,
        output vsync_n,
        output de,
        output red,
        output green,
        output blue
    );
endinterface

// File: rtl/tms9918_vga_encoder.sv
// TMS9918A to VGA output encoder.
// Positions are derived purely from sync edges in the incoming doubled-rate
// stream: h_pos restarts on each sync_h rise, v_pos restarts on each sync_v
// rise and advances on sync_h rises. Both counters saturate so that a missing
// sync leaves the outputs idle. A two-stage pipeline (capture, then decode)
// produces active-low syncs, data enable and palette RGB one enable later.
module tms9918_vga_encoder #(
    parameter int HSYNC_LEN   = 96,
    parameter int H_START     = 144,
    parameter int H_ACTIVE    = 512,
    parameter int VSYNC_LINES = 2,
    parameter int V_START     = 35,
    parameter int V_ACTIVE    = 384
) (
    input  logic                  clk,
    input  logic                  reset,
    tms9918_vga_encoder_if.slave  vid
);

    localparam logic [10:0] H_MAX      = 11'd2047;
    localparam logic [9:0]  V_MAX      = 10'd1023;
    localparam logic [10:0] HSYNC_END  = 11'(HSYNC_LEN);
    localparam logic [10:0] H_FIRST    = 11'(H_START);
    localparam logic [10:0] H_END      = 11'(H_START + H_ACTIVE);
    localparam logic [9:0]  VSYNC_END  = 10'(VSYNC_LINES);
    localparam logic [9:0]  V_FIRST    = 10'(V_START);
    localparam logic [9:0]  V_END      = 10'(V_START + V_ACTIVE);

    // Fixed TMS9918A palette; index 0 (transparent) is shown as black.
    function automatic logic [23:0] palette_lookup(input logic [3:0] idx);
        logic [23:0] rgb;
        case (idx)
            4'd0:    rgb = 24'h000000;
            4'd1:    rgb = 24'h000000;
            4'd2:    rgb = 24'h21C842;
            4'd3:    rgb = 24'h5EDC78;
            4'd4:    rgb = 24'h5455ED;
            4'd5:    rgb = 24'h7D76FC;
            4'd6:    rgb = 24'hD4524D;
            4'd7:    rgb = 24'h42EBF5;
            4'd8:    rgb = 24'hFC5554;
            4'd9:    rgb = 24'hFF7978;
            4'd10:   rgb = 24'hD4C154;
            4'd11:   rgb = 24'hE6CE80;
            4'd12:   rgb = 24'h21B03B;
            4'd13:   rgb = 24'hC95BBA;
            4'd14:   rgb = 24'hCCCCCC;
            default: rgb = 24'hFFFFFF;
        endcase
        return rgb;
    endfunction

    // Edge detectors and position counters
    logic        last_h_q, last_v_q;
    logic [10:0] h_pos_q, h_pos_d;
    logic [9:0]  v_pos_q, v_pos_d;
    logic        rise_h, rise_v;

    // Stage 1: captured sample
    logic        s1_valid_q;
    logic [3:0]  s1_color_q;
    logic        s1_cburst_q;
    logic [10:0] s1_h_q;
    logic [9:0]  s1_v_q;

    // Stage 2: decoded outputs
    logic        hsync_n_q, hsync_n_d;
    logic        vsync_n_q, vsync_n_d;
    logic        de_q, de_d;
    logic [7:0]  red_q, green_q, blue_q;
    logic [23:0] pal_rgb;
    logic [7:0]  chan_d [3];
    logic        h_win, v_win;

    // Sync edge detection and next sample position (committed only on clk_en)
    always_comb begin
        rise_h  = vid.sync_h_in & ~last_h_q;
        rise_v  = vid.sync_v_in & ~last_v_q;
        h_pos_d = h_pos_q;
        v_pos_d = v_pos_q;
        if (rise_h) begin
            h_pos_d = 11'd0;
        end else if (h_pos_q != H_MAX) begin
            h_pos_d = h_pos_q + 11'd1;
        end
        // A vertical sync edge wins over a coincident horizontal one so the
        // first line of the frame is line 0, not line 1.
        if (rise_v) begin
            v_pos_d = 10'd0;
        end else if (rise_h && (v_pos_q != V_MAX)) begin
            v_pos_d = v_pos_q + 10'd1;
        end
    end

    // Edge history, position counters and stage-1 capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // Edge history starts high so a sync held through reset release
            // is not mistaken for a fresh edge.
            last_h_q    <= 1'b1;
            last_v_q    <= 1'b1;
            h_pos_q     <= H_MAX;
            v_pos_q     <= V_MAX;
            s1_valid_q  <= 1'b0;
            s1_color_q  <= 4'd0;
            s1_cburst_q <= 1'b0;
            s1_h_q      <= 11'd0;
            s1_v_q      <= 10'd0;
        end else if (vid.clk_en) begin
            last_h_q    <= vid.sync_h_in;
            last_v_q    <= vid.sync_v_in;
            h_pos_q     <= h_pos_d;
            v_pos_q     <= v_pos_d;
            // The valid flag keeps the all-zero reset contents of stage 1
            // from being decoded as position (0,0), which would emit a
            // spurious sync pulse on the first enable after reset.
            s1_valid_q  <= 1'b1;
            s1_color_q  <= vid.color_in;
            s1_cburst_q <= vid.cburst_in;
            s1_h_q      <= h_pos_d;
            s1_v_q      <= v_pos_d;
        end
    end

    // Decode of the captured sample into sync, enable and palette colour
    always_comb begin
        h_win     = (s1_h_q >= H_FIRST) && (s1_h_q < H_END);
        v_win     = (s1_v_q >= V_FIRST) && (s1_v_q < V_END);
        hsync_n_d = ~(s1_valid_q & (s1_h_q < HSYNC_END));
        vsync_n_d = ~(s1_valid_q & (s1_v_q < VSYNC_END));
        de_d      = s1_valid_q & h_win & v_win & ~s1_cburst_q;
        pal_rgb   = palette_lookup(s1_color_q);
    end

    // Per-channel blanking: channel 0 is blue, 1 green, 2 red
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign chan_d[gi] = pal_rgb[gi*8 +: 8] & {8{de_d}};
        end
    endgenerate

    // Stage-2 output registers, updated once per pixel enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
            de_q      <= 1'b0;
            red_q     <= 8'd0;
            green_q   <= 8'd0;
            blue_q    <= 8'd0;
        end else if (vid.clk_en) begin
            hsync_n_q <= hsync_n_d;
            vsync_n_q <= vsync_n_d;
            de_q      <= de_d;
            red_q     <= chan_d[2];
            green_q   <= chan_d[1];
            blue_q    <= chan_d[0];
        end
    end

    assign vid.hsync_n = hsync_n_q;
    assign vid.vsync_n = vsync_n_q;
    assign vid.de      = de_q;
    assign vid.red     = red_q;
    assign vid.green   = green_q;
    assign vid.blue    = blue_q;

endmodule
